fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined ARM core; sits directly upstream of the combinational instruction memory.
- Owns the program counter (PC) and drives the memory word address.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles stall, flush and PC redirect from execute (branch) and writeback (write to R15).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)
WIDTH, 32, address/instruction/data width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_f  input  1  hold PC (from hazard unit)
stall_d  input  1  hold IF/ID register
flush_d  input  1  replace IF/ID contents with bubble
branch_taken_e  input  1  branch resolved taken in execute
branch_target_e  input  WIDTH  branch target address
pc_src_w  input  1  writeback writes R15
result_w  input  WIDTH  writeback value for R15
imem_addr  output  WIDTH  byte address to instruction memory (= pc_f)
imem_rd  input  WIDTH  instruction word returned combinationally
instr_d  output  WIDTH  IF/ID instruction
pc_d  output  WIDTH  IF/ID address of instr_d
pc_plus8_d  output  WIDTH  IF/ID pc_d+8 (ARM R15 read value)
valid_d  output  1  IF/ID holds a real instruction
fetch_count  output  WIDTH  instructions delivered to decode, saturating

Behaviour:
- Reset (synchronous, overrides all inputs):
  - pc_f = RESET_PC
  - instr_d = 0, pc_d = 0, pc_plus8_d = 0
  - valid_d = 0, fetch_count = 0
- imem_addr = pc_f, combinational, no latency. imem_rd is valid in the same cycle.
- Next PC, in priority order:
  1. branch_taken_e -> branch_target_e
  2. pc_src_w -> result_w
  3. otherwise -> pc_f + 4
- Next-PC alignment: bits [1:0] are forced to 0 on every load.
- Next-PC wrap: add is modulo 2^WIDTH, so FFFF_FFFC + 4 = 0000_0000.
- PC register update:
  - Loads next PC when stall_f = 0.
  - A redirect (branch_taken_e or pc_src_w) loads even when stall_f = 1; redirects are never dropped.
  - Plain sequential increment is suppressed by stall_f.
- IF/ID register, in priority order:
  1. flush_d = 1 -> instr_d = 0, pc_d = 0, pc_plus8_d = 0, valid_d = 0. Flush wins over stall_d.
  2. stall_d = 1 -> all IF/ID outputs hold.
  3. otherwise -> instr_d = imem_rd, pc_d = pc_f, pc_plus8_d = pc_f + 8 (modulo 2^WIDTH), valid_d = 1.
- fetch_count:
  - Increments by 1 on each edge where IF/ID loads with valid_d = 1 (case 3).
  - Holds at FFFF_FFFF (saturates).
- Flush responsibility: the block does not self-flush on redirect. The hazard unit asserts flush_d in the same cycle as branch_taken_e.
- Latency: instruction at pc_f appears on instr_d one cycle later. First valid_d is one cycle after reset deassertion.
- Reset mid-operation: all state returns to reset values on that edge; in-flight instruction is discarded.

Test Plan:
1. Reset held 2 cycles, then released; memory word0 = E04F000F, word1 = E2802005 -> cycle after release: imem_addr = 4, instr_d = E04F000F, pc_d = 0, pc_plus8_d = 8, valid_d = 1; next cycle: instr_d = E2802005, fetch_count = 2.
2. Free-running until pc_f = 0x20, then branch_taken_e = 1 with branch_target_e = 0x4B, plus flush_d = 1 -> next imem_addr = 0x48, valid_d = 0, fetch_count unchanged that edge.
3. stall_f = stall_d = 1 for 3 cycles at pc_f = 0x10 -> imem_addr stays 0x10, IF/ID outputs and fetch_count frozen; release -> sequence resumes at 0x14.
4. Simultaneous branch_taken_e (target 0x40), pc_src_w (result_w 0x80) and stall_f = 1 -> pc_f = 0x40. Same cycle flush_d = stall_d = 1 -> bubble loaded.
5. pc_src_w = 1, result_w = FFFF_FFFC -> next cycle pc_f = FFFF_FFFC; following cycle pc_f = 0, pc_plus8_d = 0000_0004.
6. Assert reset while pc_f = 0x30 and valid_d = 1 -> next edge pc_f = RESET_PC, valid_d = 0, fetch_count = 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and captures the fetched word into the IF/ID pipeline register.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             branch_taken_e,
  input  logic [WIDTH-1:0] branch_target_e,
  input  logic             pc_src_w,
  input  logic [WIDTH-1:0] result_w,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rd,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus8_d,
  output logic             valid_d,
  output logic [WIDTH-1:0] fetch_count
);

  logic [WIDTH-1:0] pc_f;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_plus8;
  logic [WIDTH-1:0] pc_next;
  logic             redirect;
  logic             pc_load;
  logic             ifid_load;
  logic             count_sat;

  assign imem_addr = pc_f;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pc_plus4  = pc_f + WIDTH'(4);
    pc_plus8  = pc_f + WIDTH'(8);
    redirect  = branch_taken_e || pc_src_w;
    pc_next   = pc_plus4;
    if (branch_taken_e) begin
      pc_next = branch_target_e;
    end else if (pc_src_w) begin
      pc_next = result_w;
    end
    pc_next[1:0] = 2'b00;
    // A redirect must never be lost, so it punches through a fetch stall.
    pc_load   = redirect || !stall_f;
    ifid_load = !flush_d && !stall_d;
    count_sat = (fetch_count == '1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else if (pc_load) begin
      pc_f <= pc_next;
    end
  end

  // Flush outranks stall: a squashed instruction must not linger in decode.
  always_ff @(posedge clk) begin
    if (reset || flush_d) begin
      instr_d    <= '0;
      pc_d       <= '0;
      pc_plus8_d <= '0;
      valid_d    <= 1'b0;
    end else if (ifid_load) begin
      instr_d    <= imem_rd;
      pc_d       <= pc_f;
      pc_plus8_d <= pc_plus8;
      valid_d    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (ifid_load && !count_sat) begin
      fetch_count <= fetch_count + WIDTH'(1);
    end
  end

endmodule
